// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field widths, rounding-mode encodings
// and integer saturation constants used by the float-to-int converter.
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [31:0] SAT_S_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_S_MIN = 32'h8000_0000;
  localparam logic [31:0] SAT_U_MAX = 32'hFFFF_FFFF;

  // Biased exponent at which the significand is already an integer (E = 23).
  localparam logic [EXP_W-1:0] EXP_ALIGN = 8'd150;
  // Smallest biased exponent that still reaches the guard bit (E = -1).
  localparam logic [EXP_W-1:0] EXP_GUARD = 8'd126;
  // Largest biased exponent whose magnitude fits in 32 bits (E = 31).
  localparam logic [EXP_W-1:0] EXP_MAX32 = 8'd158;

  // All-ones exponent with a nonzero fraction encodes a NaN.
  function automatic logic is_nan(input logic [31:0] op);
    return (op[30:23] == 8'hFF) && (op[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fp_shift_round.sv
// Aligns a 24-bit significand to an integer magnitude, collecting
// guard/sticky bits, and applies the rounding increment. Exponents above
// the 32-bit range produce an unspecified magnitude; the caller saturates.
module fp_shift_round
  import fpu_pkg::*;
(
  input  logic              i_sign,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic [FRAC_W:0]   i_man,
  input  logic [2:0]        i_rm,
  output logic [32:0]       o_mag,
  output logic              o_inexact
);

  logic [47:0] w_ext;
  logic [31:0] w_int;
  logic [4:0]  w_rsh;
  logic [3:0]  w_lsh;
  logic        w_guard;
  logic        w_sticky;
  logic        w_inc;

  // Alignment: left shift for large exponents, right shift with guard/sticky otherwise.
  always_comb begin
    w_ext    = 48'd0;
    w_int    = 32'd0;
    w_rsh    = 5'd0;
    w_lsh    = 4'd0;
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    if (i_exp >= EXP_ALIGN) begin
      w_lsh = (i_exp > EXP_MAX32) ? 4'd8 : 4'(i_exp - EXP_ALIGN);
      w_int = {8'd0, i_man} << w_lsh;
    end else if (i_exp >= EXP_GUARD) begin
      // Shift of 1..24: the dropped bits land in w_ext[23:0].
      w_rsh    = 5'(EXP_ALIGN - i_exp);
      w_ext    = {i_man, 24'd0} >> w_rsh;
      w_int    = {8'd0, w_ext[47:24]};
      w_guard  = w_ext[23];
      w_sticky = |w_ext[22:0];
    end else begin
      // Far below one half: everything is sticky.
      w_sticky = |i_man;
    end
  end

  // Rounding increment decision; RTZ and reserved encodings truncate.
  always_comb begin
    w_inc = 1'b0;
    case (i_rm)
      RM_RNE:  w_inc = w_guard & (w_sticky | w_int[0]);
      RM_RDN:  w_inc = i_sign & (w_guard | w_sticky);
      RM_RUP:  w_inc = ~i_sign & (w_guard | w_sticky);
      RM_RMM:  w_inc = w_guard;
      default: w_inc = 1'b0;
    endcase
  end

  assign o_mag     = {1'b0, w_int} + {32'd0, w_inc};
  assign o_inexact = w_guard | w_sticky;

endmodule

// File: rtl/fpu_convert.sv
// Binary32 to 32-bit integer converter (FCVT.W.S / FCVT.WU.S) with
// saturation, NV/NX flags and a single output register stage.
// Optional feature macro: FP_CONVERT_RM_EN adds the rm port (otherwise RTZ).
module fpu_convert
  import fpu_pkg::*;
#(
  parameter int XLEN = 32
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  A,
  input  logic             is_unsigned,
`ifdef FP_CONVERT_RM_EN
  input  logic [2:0]       rm,
`endif
  output logic             out_valid,
  output logic [31:0]      result,
  output logic             flag_nv,
  output logic             flag_nx
);

  logic              w_sign;
  logic [EXP_W-1:0]  w_exp;
  logic [FRAC_W:0]   w_man;
  logic              w_nan;
  logic              w_big;
  logic [2:0]        w_rm;
  logic [32:0]       w_mag;
  logic              w_inexact;
  logic [31:0]       w_res;
  logic              w_nv;
  logic              w_nx;

  logic              r_out_valid;
  logic [31:0]       r_result;
  logic              r_nv;
  logic              r_nx;

  assign w_sign = A[XLEN-1];
  assign w_exp  = A[30:23];
  assign w_man  = {(w_exp != 8'd0), A[22:0]};
  assign w_nan  = is_nan(A[31:0]);
  // Magnitude at least 2^32 (also covers infinities).
  assign w_big  = (w_exp > EXP_MAX32);

`ifdef FP_CONVERT_RM_EN
  assign w_rm = rm;
`else
  assign w_rm = RM_RTZ;
`endif

  fp_shift_round u_shift_round (
    .i_sign    (w_sign),
    .i_exp     (w_exp),
    .i_man     (w_man),
    .i_rm      (w_rm),
    .o_mag     (w_mag),
    .o_inexact (w_inexact)
  );

  // Classification and saturation of the rounded magnitude into the result and flags.
  always_comb begin
    w_res = 32'd0;
    w_nv  = 1'b0;
    w_nx  = 1'b0;
    if (w_nan) begin
      w_res = is_unsigned ? SAT_U_MAX : SAT_S_MAX;
      w_nv  = 1'b1;
    end else if (is_unsigned) begin
      if (w_sign) begin
        if (w_big || (w_mag != 33'd0)) begin
          w_res = 32'd0;
          w_nv  = 1'b1;
        end else begin
          w_res = 32'd0;
          w_nx  = w_inexact;
        end
      end else if (w_big || w_mag[32]) begin
        w_res = SAT_U_MAX;
        w_nv  = 1'b1;
      end else begin
        w_res = w_mag[31:0];
        w_nx  = w_inexact;
      end
    end else begin
      if (w_sign) begin
        if (w_big || (w_mag > {1'b0, SAT_S_MIN})) begin
          w_res = SAT_S_MIN;
          w_nv  = 1'b1;
        end else begin
          w_res = 32'd0 - w_mag[31:0];
          w_nx  = w_inexact;
        end
      end else if (w_big || (w_mag > {1'b0, SAT_S_MAX})) begin
        w_res = SAT_S_MAX;
        w_nv  = 1'b1;
      end else begin
        w_res = w_mag[31:0];
        w_nx  = w_inexact;
      end
    end
  end

  // Output registers: valid follows in_valid, data/flags load only on a valid operand.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= 32'd0;
      r_nv        <= 1'b0;
      r_nx        <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_res;
        r_nv     <= w_nv;
        r_nx     <= w_nx;
      end else begin
        r_result <= r_result;
        r_nv     <= r_nv;
        r_nx     <= r_nx;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flag_nv   = r_nv;
  assign flag_nx   = r_nx;

endmodule

// File: tb/tb_fpu_convert.sv
// Self-checking bench for fpu_convert: scoreboard of expected results
// pushed when an operand is driven and popped one cycle later.
// Rounding-mode vectors are included when FP_CONVERT_RM_EN is defined.
module tb_fpu_convert;
  import fpu_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic        uns;
    logic [2:0]  rmode;
    logic [31:0] res;
    logic        nv;
    logic        nx;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        nv;
    logic        nx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] A;
  logic        is_unsigned;
  logic        out_valid;
  logic [31:0] result;
  logic        flag_nv;
  logic        flag_nx;
`ifdef FP_CONVERT_RM_EN
  logic [2:0]  rm;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  fpu_convert #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .A           (A),
    .is_unsigned (is_unsigned),
`ifdef FP_CONVERT_RM_EN
    .rm          (rm),
`endif
    .out_valid   (out_valid),
    .result      (result),
    .flag_nv     (flag_nv),
    .flag_nx     (flag_nx)
  );

  function automatic vec_t mk(input logic [31:0] a, input logic uns, input logic [2:0] rmode,
                              input logic [31:0] res, input logic nv, input logic nx);
    vec_t v;
    v.a = a; v.uns = uns; v.rmode = rmode; v.res = res; v.nv = nv; v.nx = nx;
    return v;
  endfunction

  // Drive one valid operand on the falling edge and record its expected result.
  task automatic drive(input vec_t v);
    exp_t e;
    @(negedge clk);
    in_valid    = 1'b1;
    A           = v.a;
    is_unsigned = v.uns;
`ifdef FP_CONVERT_RM_EN
    rm          = v.rmode;
`endif
    e.res = v.res; e.nv = v.nv; e.nx = v.nx;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; A = 32'h404C_CCCC; is_unsigned = 1'b0;
`ifdef FP_CONVERT_RM_EN
    rm = RM_RTZ;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'd0 || flag_nv !== 1'b0 || flag_nx !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got v=%b res=%h nv=%b nx=%b, expected all zero", out_valid, result, flag_nv, flag_nx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(32'h3F80_0000, 1'b0, RM_RTZ, 32'd1, 1'b0, 1'b0));
    @(posedge clk); #1;
    begin
      exp_t e = sb_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || result !== e.res || flag_nv !== e.nv || flag_nx !== e.nx) begin
        errors++;
        $display("FAIL reset_release: got v=%b res=%h nv=%b nx=%b, expected v=1 res=%h nv=%b nx=%b",
                 out_valid, result, flag_nv, flag_nx, e.res, e.nv, e.nx);
      end
    end
  endtask

  task automatic test_truncate();
    vec_t v[$];
    v.push_back(mk(32'h404C_CCCC, 1'b0, RM_RTZ, 32'd3,  1'b0, 1'b1));
    v.push_back(mk(32'h428C_3EFA, 1'b0, RM_RTZ, 32'd70, 1'b0, 1'b1));
    v.push_back(mk(32'h4171_999A, 1'b0, RM_RTZ, 32'd15, 1'b0, 1'b1));
    v.push_back(mk(32'h4034_B4B5, 1'b0, RM_RTZ, 32'd2,  1'b0, 1'b1));
    v.push_back(mk(32'h4B00_0001, 1'b0, RM_RTZ, 32'h0080_0001, 1'b0, 1'b0));
    v.push_back(mk(32'h3F00_0000, 1'b1, RM_RTZ, 32'd0,  1'b0, 1'b1));
    foreach (v[i]) begin
      exp_t e;
      drive(v[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || result !== e.res || flag_nv !== e.nv || flag_nx !== e.nx) begin
        errors++;
        $display("FAIL truncate[%0d] A=%h: got v=%b res=%h nv=%b nx=%b, expected v=1 res=%h nv=%b nx=%b",
                 i, v[i].a, out_valid, result, flag_nv, flag_nx, e.res, e.nv, e.nx);
      end
    end
  endtask

  task automatic test_negative();
    vec_t v[$];
    v.push_back(mk(32'hBDFC_2880, 1'b0, RM_RTZ, 32'd0,         1'b0, 1'b1));
    v.push_back(mk(32'hBDFC_2880, 1'b1, RM_RTZ, 32'd0,         1'b0, 1'b1));
    v.push_back(mk(32'hC000_0000, 1'b1, RM_RTZ, 32'd0,         1'b1, 1'b0));
    v.push_back(mk(32'hBFC0_0000, 1'b0, RM_RTZ, 32'hFFFF_FFFF, 1'b0, 1'b1));
    v.push_back(mk(32'h8000_0000, 1'b1, RM_RTZ, 32'd0,         1'b0, 1'b0));
    v.push_back(mk(32'h0000_0001, 1'b0, RM_RTZ, 32'd0,         1'b0, 1'b1));
    v.push_back(mk(32'h0000_0000, 1'b0, RM_RTZ, 32'd0,         1'b0, 1'b0));
    foreach (v[i]) begin
      exp_t e;
      drive(v[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || result !== e.res || flag_nv !== e.nv || flag_nx !== e.nx) begin
        errors++;
        $display("FAIL negative[%0d] A=%h: got v=%b res=%h nv=%b nx=%b, expected v=1 res=%h nv=%b nx=%b",
                 i, v[i].a, out_valid, result, flag_nv, flag_nx, e.res, e.nv, e.nx);
      end
    end
  endtask

  task automatic test_saturation();
    vec_t v[$];
    v.push_back(mk(32'h7FC0_0000, 1'b0, RM_RTZ, 32'h7FFF_FFFF, 1'b1, 1'b0));
    v.push_back(mk(32'h7FC0_0000, 1'b1, RM_RTZ, 32'hFFFF_FFFF, 1'b1, 1'b0));
    v.push_back(mk(32'h4F00_0000, 1'b0, RM_RTZ, 32'h7FFF_FFFF, 1'b1, 1'b0));
    v.push_back(mk(32'hCF00_0000, 1'b0, RM_RTZ, 32'h8000_0000, 1'b0, 1'b0));
    v.push_back(mk(32'h4F00_0000, 1'b1, RM_RTZ, 32'h8000_0000, 1'b0, 1'b0));
    v.push_back(mk(32'hCF00_0001, 1'b0, RM_RTZ, 32'h8000_0000, 1'b1, 1'b0));
    v.push_back(mk(32'h7F80_0000, 1'b0, RM_RTZ, 32'h7FFF_FFFF, 1'b1, 1'b0));
    v.push_back(mk(32'hFF80_0000, 1'b0, RM_RTZ, 32'h8000_0000, 1'b1, 1'b0));
    v.push_back(mk(32'hFF80_0000, 1'b1, RM_RTZ, 32'd0,         1'b1, 1'b0));
    v.push_back(mk(32'h4F80_0000, 1'b1, RM_RTZ, 32'hFFFF_FFFF, 1'b1, 1'b0));
    v.push_back(mk(32'h4F7F_FFFF, 1'b1, RM_RTZ, 32'hFFFF_FF00, 1'b0, 1'b0));
    v.push_back(mk(32'h4F7F_FFFF, 1'b0, RM_RTZ, 32'h7FFF_FFFF, 1'b1, 1'b0));
    foreach (v[i]) begin
      exp_t e;
      drive(v[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || result !== e.res || flag_nv !== e.nv || flag_nx !== e.nx) begin
        errors++;
        $display("FAIL saturation[%0d] A=%h: got v=%b res=%h nv=%b nx=%b, expected v=1 res=%h nv=%b nx=%b",
                 i, v[i].a, out_valid, result, flag_nv, flag_nx, e.res, e.nv, e.nx);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    drive(mk(32'h428C_3EFA, 1'b0, RM_RTZ, 32'd70, 1'b0, 1'b1));
    @(posedge clk); #1;
    e = sb_q.pop_front();
    @(negedge clk);
    in_valid = 1'b0;
    A        = 32'h7FC0_0000;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || result !== e.res || flag_nv !== e.nv || flag_nx !== e.nx) begin
      errors++;
      $display("FAIL hold_idle: got v=%b res=%h nv=%b nx=%b, expected v=0 res=%h nv=%b nx=%b",
               out_valid, result, flag_nv, flag_nx, e.res, e.nv, e.nx);
    end
  endtask

`ifdef FP_CONVERT_RM_EN
  task automatic test_rounding();
    vec_t v[$];
    v.push_back(mk(32'h4020_0000, 1'b0, RM_RNE, 32'd2,         1'b0, 1'b1));
    v.push_back(mk(32'h4020_0000, 1'b0, RM_RUP, 32'd3,         1'b0, 1'b1));
    v.push_back(mk(32'h4020_0000, 1'b0, RM_RMM, 32'd3,         1'b0, 1'b1));
    v.push_back(mk(32'hC020_0000, 1'b0, RM_RDN, 32'hFFFF_FFFD, 1'b0, 1'b1));
    v.push_back(mk(32'h4060_0000, 1'b0, RM_RNE, 32'd4,         1'b0, 1'b1));
    v.push_back(mk(32'h4020_0000, 1'b0, 3'b101, 32'd2,         1'b0, 1'b1));
    v.push_back(mk(32'hBFC0_0000, 1'b1, RM_RUP, 32'd0,         1'b1, 1'b0));
    foreach (v[i]) begin
      exp_t e;
      drive(v[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || result !== e.res || flag_nv !== e.nv || flag_nx !== e.nx) begin
        errors++;
        $display("FAIL rounding[%0d] A=%h rm=%b: got v=%b res=%h nv=%b nx=%b, expected v=1 res=%h nv=%b nx=%b",
                 i, v[i].a, v[i].rmode, out_valid, result, flag_nv, flag_nx, e.res, e.nv, e.nx);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_truncate();
    test_negative();
    test_saturation();
    test_hold();
`ifdef FP_CONVERT_RM_EN
    test_rounding();
`endif
    @(negedge clk);
    in_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
